parity_frame_checker: RTL and testbench

//  Multi-channel streaming parity generator/checker, the sequential successor to single-word XOR parity.

---
 rtl/parity_frame_pkg.sv | 7 +
 rtl/parity_frame_chan.sv | 94 +++++++++
 rtl/parity_frame_checker.sv | 51 +++++
 tb/tb_parity_frame_checker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types for the multi-channel streaming parity frame checker.
package parity_frame_pkg;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} pf_state_e;
  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} pf_mode_e;

endpackage

// File: rtl/parity_frame_chan.sv
// One channel: frame FSM, running parity, saturating beat count and a
// single-entry result register released by out_ready.
module parity_frame_chan
  import parity_frame_pkg::*;
#(
  parameter int W       = 32,
  parameter int MAX_LEN = 256,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mode_odd,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic          in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_parity,
  output logic          out_err,
  output logic          out_ovf,
  output logic [LW-1:0] out_len
);

  pf_state_e       state, state_nx;
  pf_mode_e        mode;
  logic            acc, acc_nx;
  logic [LW-1:0]   len, len_nx;
  logic            ovf, ovf_nx;
  logic            accept;
  logic            first;

  function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] v);
    return (v >= LW'(MAX_LEN)) ? LW'(MAX_LEN) : v + LW'(1);
  endfunction

  assign mode     = pf_mode_e'(mode_odd);
  assign in_ready = (state != HOLD) | out_ready;
  assign accept   = in_valid & in_ready;
  // Any beat accepted outside ACC opens a new frame, including the
  // release-and-restart case in HOLD.
  assign first    = (state != ACC);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    len_nx   = len;
    ovf_nx   = ovf;
    if (accept) begin
      if (first) begin
        acc_nx = (^in_data) ^ (mode == PAR_ODD);
        len_nx = LW'(1);
        ovf_nx = 1'b0;
      end else begin
        acc_nx = acc ^ (^in_data);
        len_nx = sat_inc(len);
        ovf_nx = ovf | (len == LW'(MAX_LEN));
      end
      state_nx = in_last ? HOLD : ACC;
    end else if ((state == HOLD) && out_ready) begin
      state_nx = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= 1'b0;
      len        <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
      out_ovf    <= 1'b0;
      out_len    <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      len   <= len_nx;
      ovf   <= ovf_nx;
      if (accept && in_last) begin
        out_valid  <= 1'b1;
        out_parity <= acc_nx;
        out_err    <= acc_nx ^ in_exp;
        out_ovf    <= ovf_nx;
        out_len    <= len_nx;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Multi-channel streaming parity generator/checker: CH independent
// parity_frame_chan instances sharing only clock and reset.
module parity_frame_checker
  import parity_frame_pkg::*;
#(
  parameter int W       = 32,
  parameter int CH      = 4,
  parameter int MAX_LEN = 256
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                mode_odd,
  input  logic [CH-1:0]                       in_valid,
  output logic [CH-1:0]                       in_ready,
  input  logic [CH*W-1:0]                     in_data,
  input  logic [CH-1:0]                       in_last,
  input  logic [CH-1:0]                       in_exp,
  output logic [CH-1:0]                       out_valid,
  input  logic [CH-1:0]                       out_ready,
  output logic [CH-1:0]                       out_parity,
  output logic [CH-1:0]                       out_err,
  output logic [CH-1:0]                       out_ovf,
  output logic [CH*$clog2(MAX_LEN+1)-1:0]     out_len
);

  localparam int LW = $clog2(MAX_LEN + 1);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    parity_frame_chan #(
      .W       (W),
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_odd   (mode_odd),
      .in_valid   (in_valid[c]),
      .in_ready   (in_ready[c]),
      .in_data    (in_data[c*W +: W]),
      .in_last    (in_last[c]),
      .in_exp     (in_exp[c]),
      .out_valid  (out_valid[c]),
      .out_ready  (out_ready[c]),
      .out_parity (out_parity[c]),
      .out_err    (out_err[c]),
      .out_ovf    (out_ovf[c]),
      .out_len    (out_len[c*LW +: LW])
    );
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: frame-level reference model plus directed
// and randomized per-channel traffic.
module tb_parity_frame_checker;

  localparam int W       = 32;
  localparam int CH      = 4;
  localparam int MAX_LEN = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic              clk;
  logic              rst_n;
  logic              mode_odd;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [CH*W-1:0]   in_data;
  logic [CH-1:0]     in_last;
  logic [CH-1:0]     in_exp;
  logic [CH-1:0]     out_valid;
  logic [CH-1:0]     out_ready;
  logic [CH-1:0]     out_parity;
  logic [CH-1:0]     out_err;
  logic [CH-1:0]     out_ovf;
  logic [CH*LW-1:0]  out_len;

  int checks = 0;
  int fails  = 0;

  parity_frame_checker #(.W(W), .CH(CH), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_odd   (mode_odd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_exp     (in_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_err    (out_err),
    .out_ovf    (out_ovf),
    .out_len    (out_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, c, act, exp, $time);
    end
  endtask

  // Frame-level reference: a frame is the list of accepted beats; its result
  // is the XOR of all beat parities, flipped by the first beat's mode.
  bit pend   [CH];
  bit inframe[CH];
  bit fmode  [CH];
  bit px     [CH];
  int nb     [CH];
  bit e_par  [CH];
  bit e_err  [CH];
  bit e_ovf  [CH];
  int e_len  [CH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        pend[c] = 0; inframe[c] = 0; nb[c] = 0; px[c] = 0; fmode[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit rdy;
        logic [W-1:0] d;
        rdy = !pend[c] || out_ready[c];
        if (pend[c] && out_ready[c]) pend[c] = 0;
        if (in_valid[c] && rdy) begin
          d = in_data[c*W +: W];
          if (!inframe[c]) begin
            inframe[c] = 1; fmode[c] = mode_odd; nb[c] = 0; px[c] = 0;
          end
          nb[c]++;
          px[c] = px[c] ^ (^d);
          if (in_last[c]) begin
            e_par[c]   = px[c] ^ fmode[c];
            e_err[c]   = e_par[c] ^ in_exp[c];
            e_ovf[c]   = nb[c] > MAX_LEN;
            e_len[c]   = (nb[c] > MAX_LEN) ? MAX_LEN : nb[c];
            pend[c]    = 1;
            inframe[c] = 0;
          end
        end
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (!rst_n) begin
        chk("rst_out_valid", c, 32'(out_valid[c]), 32'd0);
        chk("rst_in_ready", c, 32'(in_ready[c]), 32'd1);
        chk("rst_out_len", c, 32'(out_len[c*LW +: LW]), 32'd0);
      end else begin
        chk("out_valid", c, 32'(out_valid[c]), 32'(pend[c]));
        chk("in_ready", c, 32'(in_ready[c]), 32'(!pend[c] || out_ready[c]));
        if (pend[c]) begin
          chk("out_parity", c, 32'(out_parity[c]), 32'(e_par[c]));
          chk("out_err", c, 32'(out_err[c]), 32'(e_err[c]));
          chk("out_ovf", c, 32'(out_ovf[c]), 32'(e_ovf[c]));
          chk("out_len", c, 32'(out_len[c*LW +: LW]), 32'(e_len[c]));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_beat(input int c, input logic [W-1:0] d, input logic l, input logic e, input logic m);
    in_valid[c]        = 1'b1;
    in_data[c*W +: W]  = d;
    in_last[c]         = l;
    in_exp[c]          = e;
    mode_odd           = m;
  endtask

  task automatic send(input int c, input logic [W-1:0] d, input logic l, input logic e, input logic m);
    set_beat(c, d, l, e, m);
    cyc();
    in_valid[c] = 1'b0;
  endtask

  task automatic chk_res(input string name, input int c, input logic p, input logic e, input logic o, input int l);
    chk({name, "_valid"}, c, 32'(out_valid[c]), 32'd1);
    chk({name, "_parity"}, c, 32'(out_parity[c]), 32'(p));
    chk({name, "_err"}, c, 32'(out_err[c]), 32'(e));
    chk({name, "_ovf"}, c, 32'(out_ovf[c]), 32'(o));
    chk({name, "_len"}, c, 32'(out_len[c*LW +: LW]), 32'(l));
  endtask

  initial begin
    rst_n     = 1'b1;
    mode_odd  = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    in_exp    = '0;
    out_ready = '1;
    #1 rst_n = 1'b0;

    // 1: reset values
    repeat (3) cyc();
    chk("reset_out_valid", 0, 32'(out_valid), 32'd0);
    chk("reset_outs", 0, 32'({out_parity, out_err, out_ovf}), 32'd0);
    chk("reset_out_len", 0, 32'(out_len), 32'd0);
    chk("reset_in_ready", 0, 32'(in_ready), 32'hF);
    rst_n = 1'b1;
    cyc();

    // 2: even 1-beat frame
    send(0, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
    chk_res("even1", 0, 1'b1, 1'b0, 1'b0, 1);
    cyc();

    // 3: odd 3-beat frame, then with mismatching expected bit
    send(0, 32'h1, 1'b0, 1'b0, 1'b1);
    send(0, 32'h3, 1'b0, 1'b0, 1'b0);
    send(0, 32'hF, 1'b1, 1'b0, 1'b0);
    chk_res("odd3", 0, 1'b0, 1'b0, 1'b0, 3);
    send(0, 32'h1, 1'b0, 1'b0, 1'b1);
    send(0, 32'h3, 1'b0, 1'b0, 1'b0);
    send(0, 32'hF, 1'b1, 1'b1, 1'b0);
    chk_res("odd3_err", 0, 1'b0, 1'b1, 1'b0, 3);
    cyc();

    // 4: backpressure, then release together with a new last beat
    out_ready[0] = 1'b0;
    send(0, 32'h1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      set_beat(0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk("stall_in_ready", 0, 32'(in_ready[0]), 32'd0);
      cyc();
      chk_res("stall", 0, 1'b1, 1'b1, 1'b0, 1);
    end
    out_ready[0] = 1'b1;
    send(0, 32'h3, 1'b1, 1'b0, 1'b0);
    chk_res("nobubble", 0, 1'b0, 1'b0, 1'b0, 1);
    cyc();

    // 5: overflow then a normal frame
    for (int i = 0; i < 6; i++) send(0, 32'(i + 1), 1'(i == 5), 1'b0, 1'b0);
    chk_res("ovf6", 0, 1'b1, 1'b1, 1'b1, 4);
    send(0, 32'h1, 1'b0, 1'b0, 1'b0);
    send(0, 32'h1, 1'b1, 1'b0, 1'b0);
    chk_res("after_ovf", 0, 1'b0, 1'b0, 1'b0, 2);
    cyc();

    // 6: ch1 stalled while ch0 streams five frames
    out_ready[1] = 1'b0;
    send(1, 32'h7, 1'b1, 1'b0, 1'b0);
    in_valid[1] = 1'b1;
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) send(0, $urandom, 1'(b == n - 1), 1'($urandom), 1'($urandom));
      chk("ch1_held_valid", 1, 32'(out_valid[1]), 32'd1);
      chk("ch1_held_ready", 1, 32'(in_ready[1]), 32'd0);
    end
    send(0, 32'h1, 1'b0, 1'b0, 1'b0);
    send(0, 32'h2, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 0, 32'(in_ready), 32'hF);
    in_valid = '0;
    out_ready = '1;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_no_result", 0, 32'(out_valid), 32'd0);
    send(0, 32'h0, 1'b0, 1'b0, 1'b0);
    send(0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk_res("post_rst", 0, 1'b0, 1'b0, 1'b0, 2);
    cyc();

    // Randomized traffic on all channels
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        in_valid[c]       = 1'($urandom_range(0, 3) != 0);
        out_ready[c]      = 1'($urandom_range(0, 3) != 0);
        in_last[c]        = 1'($urandom_range(0, 4) == 0);
        in_exp[c]         = 1'($urandom);
        in_data[c*W +: W] = $urandom;
      end
      mode_odd = 1'($urandom);
      cyc();
    end
    in_valid  = '0;
    out_ready = '1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
